// File: rtl/beans_arb_if.sv
// Requester-side and shared-unit-side signals of one beans_arb instance.
// The arbiter takes the slave view; requesters and the beans unit take the master view.
interface beans_arb_if #(
   parameter int N_REQ = 4
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic             res_done;
   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic             res_start;
   logic [N_REQ-1:0] done;
   logic             timeout;
   logic             busy;

   modport master (
      output req, res_done,
      input  gnt, gnt_id, res_start, done, timeout, busy
   );

   modport slave (
      input  req, res_done,
      output gnt, gnt_id, res_start, done, timeout, busy
   );
endinterface

// File: rtl/beans_arb.sv
// Round-robin arbiter/sequencer sharing one beans datapath among N_REQ requesters,
// with a per-grant watchdog that forcibly releases a stuck transaction.
module beans_arb #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input logic        clk,
   input logic        rst,
   beans_arb_if.slave bus
);
   localparam int ID_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT
   } state_e;

   state_e            state_q;
   logic [ID_W-1:0]   ptr_q;
   logic [CNT_W-1:0]  wcnt_q;
   logic [N_REQ-1:0]  gnt_q;
   logic [ID_W-1:0]   gnt_id_q;
   logic              res_start_q;
   logic [N_REQ-1:0]  done_q;
   logic              timeout_q;
   logic              busy_q;

   logic              win_vld_d;
   logic [ID_W-1:0]   win_id_d;
   logic [ID_W-1:0]   ptr_d;
   int                scan_idx;

   // Scan downward in priority so the last hit is the lowest offset from ptr_q.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      win_vld_d = 1'b0;
      win_id_d  = '0;
      scan_idx  = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         scan_idx = int'(ptr_q) + i;
         if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
         if (bus.req[scan_idx]) begin
            win_vld_d = 1'b1;
            win_id_d  = ID_W'(scan_idx);
         end
      end
   end

   assign ptr_d = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + ID_W'(1);

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         wcnt_q      <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         res_start_q <= 1'b0;
         done_q      <= '0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         res_start_q <= 1'b0;
         done_q      <= '0;
         timeout_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (win_vld_d) begin
                  state_q     <= S_START;
                  gnt_q       <= ONE_HOT0 << win_id_d;
                  gnt_id_q    <= win_id_d;
                  res_start_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_START: begin
               state_q <= S_WAIT;
               wcnt_q  <= '0;
            end
            S_WAIT: begin
               // Completion has priority over a watchdog expiry in the same cycle.
               if (bus.res_done) begin
                  state_q <= S_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= gnt_q;
                  ptr_q   <= ptr_d;
               end else if (wcnt_q == WCNT_LAST) begin
                  state_q   <= S_IDLE;
                  gnt_q     <= '0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  ptr_q     <= ptr_d;
               end else begin
                  wcnt_q <= wcnt_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.res_start = res_start_q;
   assign bus.done      = done_q;
   assign bus.timeout   = timeout_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_beans_arb.sv
// Scoreboard bench for beans_arb: a transaction-level model predicts grants and
// completions with their cycle numbers; a monitor checks what the DUT presents.
module tb_beans_arb;
   localparam int N = 4;
   localparam int T = 5;

   typedef struct {
      int id;
      int cyc;
   } gnt_exp_t;

   typedef struct {
      bit is_to;
      int id;
      int cyc;
   } cpl_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   m_ptr = 0;

   gnt_exp_t gq[$];
   cpl_exp_t cq[$];

   beans_arb_if #(.N_REQ(N)) bus ();

   beans_arb #(.N_REQ(N), .TIMEOUT(T), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // First requesting index at or after ptr, wrapping modulo N.
   function automatic int model_winner(input logic [N-1:0] pat, input int ptr);
      for (int off = 0; off < N; off++)
         if (pat[(ptr + off) % N]) return (ptr + off) % N;
      return -1;
   endfunction

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      bit active = 1'b0;
      int cur_id = 0;
      gnt_exp_t ge;
      cpl_exp_t ce;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            check("reset gnt", 32'(bus.gnt), 32'd0);
            check("reset gnt_id", 32'(bus.gnt_id), 32'd0);
            check("reset busy", 32'(bus.busy), 32'd0);
            check("reset res_start", 32'(bus.res_start), 32'd0);
            check("reset done", 32'(bus.done), 32'd0);
            check("reset timeout", 32'(bus.timeout), 32'd0);
            active = 1'b0;
         end else begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
               ge = gq.pop_front();
               check("missed grant cycle", 32'(cyc), 32'(ge.cyc));
            end
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
               ce = cq.pop_front();
               check("missed completion cycle", 32'(cyc), 32'(ce.cyc));
               active = 1'b0;
            end
            if (bus.res_start) begin
               if (gq.size() == 0) begin
                  check("unexpected res_start", 32'(bus.res_start), 32'd0);
               end else begin
                  ge = gq.pop_front();
                  check("grant cycle", 32'(cyc), 32'(ge.cyc));
                  check("grant id", 32'(bus.gnt_id), 32'(ge.id));
                  active = 1'b1;
                  cur_id = ge.id;
               end
            end
            if (bus.done != '0 || bus.timeout) begin
               if (cq.size() == 0) begin
                  check("unexpected done/timeout", {27'd0, bus.timeout, bus.done}, 32'd0);
               end else begin
                  ce = cq.pop_front();
                  check("completion cycle", 32'(cyc), 32'(ce.cyc));
                  check("timeout flag", 32'(bus.timeout), 32'(ce.is_to));
                  check("done vector", 32'(bus.done), ce.is_to ? 32'd0 : (32'd1 << ce.id));
                  active = 1'b0;
               end
            end
            check("gnt held", 32'(bus.gnt), active ? (32'd1 << cur_id) : 32'd0);
            check("busy", 32'(bus.busy), 32'(active));
            if (active) check("gnt_id held", 32'(bus.gnt_id), 32'(cur_id));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // One transaction. Entered at a negedge with the arbiter idle; d = res_done delay
   // after the start edge (0 = never), drop = scramble req (grantee bit off) once granted.
   task automatic run_txn(input logic [N-1:0] pat, input int d, input bit drop);
      int id;
      int k;
      int end_cyc;
      gnt_exp_t ge;
      cpl_exp_t ce;
      bus.req = pat;
      id = model_winner(pat, m_ptr);
      k = cyc + 1;
      ge.id = id;
      ge.cyc = k;
      gq.push_back(ge);
      tick();
      if (drop) begin
         bus.req = N'($urandom);
         bus.req[id] = 1'b0;
      end
      ce.id = id;
      if (d >= 2 && d <= T + 1) begin
         ce.is_to = 1'b0;
         end_cyc = k + d;
      end else begin
         ce.is_to = 1'b1;
         end_cyc = k + 1 + T;
      end
      ce.cyc = end_cyc;
      cq.push_back(ce);
      if (d >= 1 && d <= T + 1) begin
         wait_until(k + d - 1);
         bus.res_done = 1'b1;
         tick();
         bus.res_done = 1'b0;
      end
      wait_until(end_cyc);
      m_ptr = (id + 1) % N;
   endtask

   // Idle cycles with no requests, optionally carrying a stray res_done.
   task automatic idle_gap(input int n, input bit stray);
      bus.req = '0;
      if (stray) begin
         bus.res_done = 1'b1;
         tick();
         bus.res_done = 1'b0;
      end
      repeat (n) tick();
   endtask

   // Reset asserted for one cycle while in WAIT, followed by a res_done that must be ignored.
   task automatic reset_mid_wait(input logic [N-1:0] pat);
      gnt_exp_t ge;
      bus.req = pat;
      ge.id = model_winner(pat, m_ptr);
      ge.cyc = cyc + 1;
      gq.push_back(ge);
      repeat (3) tick();
      rst = 1'b1;
      bus.req = '0;
      tick();
      rst = 1'b0;
      bus.res_done = 1'b1;
      tick();
      bus.res_done = 1'b0;
      repeat (2) tick();
      m_ptr = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int d;
      bus.req = '0;
      bus.res_done = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      run_txn(4'b0100, 3, 1'b0);      // single request, done 3 cycles after start
      idle_gap(2, 1'b1);              // stray res_done while idle
      reset_mid_wait(4'b1000);        // ptr was 3; reset must bring it back to 0
      for (int i = 0; i < 6; i++)     // contention from ptr 0: 0,1,2,3,0,1
         run_txn(4'b1111, 2, 1'b0);
      run_txn(4'b0001, 0, 1'b0);      // watchdog expiry
      run_txn(4'b1001, 2, 1'b0);      // next pending after the timed-out grantee
      run_txn(4'b1111, T + 1, 1'b0);  // res_done on the expiry cycle
      run_txn(4'b1111, T, 1'b0);
      run_txn(4'b0010, 1, 1'b0);      // res_done during START is ignored, then expiry
      run_txn(4'b0110, 4, 1'b1);      // grantee drops req mid-transaction
      run_txn(4'b1111, 2, 1'b0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0:       d = 0;
            1:       d = 1;
            default: d = $urandom_range(2, T + 1);
         endcase
         run_txn(N'($urandom_range(1, 15)), d, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      bus.req = '0;
      repeat (4) tick();
      check("grant queue drained", 32'(gq.size()), 32'd0);
      check("completion queue drained", 32'(cq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/beans_arb.md
# beans_arb

Round-robin arbiter and sequencer that shares the single `beans` datapath among `N_REQ` requesters. It grants one requester at a time, issues a one-cycle start pulse to the shared unit, holds the grant until the unit reports completion or a watchdog expires, and then returns a completion pulse to the granted requester. It sits between the requester ports and the `beans` instance, one per shared unit.

## Interface
- `N_REQ`, 4: number of requesters; legal values are ≥ 2.
- `TIMEOUT`, 255: maximum number of WAIT cycles before the grant is forcibly released; legal values are ≥ 1.
- `CNT_W`, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.
- `clk`  in  1  the only clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  level request per requester.
- `res_done`  in  1  one-cycle completion pulse from the shared unit.
- `gnt`  out  N_REQ  one-hot grant; held for the whole transaction.
- `gnt_id`  out  $clog2(N_REQ)  binary index of the current grantee; valid while `busy` is high.
- `res_start`  out  1  one-cycle start pulse to the shared unit.
- `done`  out  N_REQ  one-hot, one-cycle completion pulse to the grantee.
- `timeout`  out  1  one-cycle pulse when the watchdog releases a grant.
- `busy`  out  1  high in START and WAIT.

## Operation
- States:
  - IDLE: no grant is held.
  - START: grant asserted and `res_start` high.
  - WAIT: waiting for `res_done` or the watchdog.
- IDLE → START when any `req` bit is high.
  - Winner: the first set bit scanning upward from pointer `ptr`, wrapping modulo N_REQ.
  - On this transition, register `gnt`, `gnt_id`, and `res_start`=1.
- START → WAIT unconditionally.
  - Clear `res_start`.
  - Clear the watchdog counter `wcnt` to 0.
- WAIT:
  - Each cycle without `res_done`, `wcnt` increments.
  - On `res_done`=1: go to IDLE, clear `gnt`, pulse `done[gnt_id]` for one cycle, set `ptr` = (gnt_id+1) mod N_REQ.
  - Otherwise, if `wcnt` == TIMEOUT-1: go to IDLE, clear `gnt`, pulse `timeout`, advance `ptr` the same way, and assert no `done` bit.
- `res_done` and watchdog expiry in the same cycle: `res_done` wins. `done` pulses and `timeout` stays 0.
- `res_done` while in IDLE or START is ignored: no state change and no outputs.
- `req` is sampled only in IDLE.
  - Dropping the grantee's `req` in START or WAIT does not abort the transaction.
  - Changes on other `req` bits are ignored until the next IDLE.
- Round-robin fairness: with all requests held continuously, every requester is granted once every N_REQ transactions.
- Reset values: state=IDLE, `ptr`=0, `wcnt`=0, `gnt`=0, `gnt_id`=0, `res_start`=0, `done`=0, `timeout`=0, `busy`=0.
- Reset mid-transaction: all outputs return to reset values on the next edge.
  - No `done` or `timeout` pulse is produced.
  - Any `res_done` arriving afterwards is ignored per the IDLE rule.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Grant latency: `req` high before edge k, with the arbiter in IDLE, gives `gnt`, `gnt_id`, `busy`, and `res_start` high from edge k.
- `res_start` is high for exactly one cycle (edge k to edge k+1).
- The earliest `res_done` honoured is the one sampled at edge k+2.
- `res_done` sampled at edge m gives, from edge m:
  - `gnt`=0 and `busy`=0;
  - `done[gnt_id]` high for one cycle.
- Watchdog: with no `res_done`, WAIT lasts exactly TIMEOUT cycles. `timeout` is high from edge k+1+TIMEOUT.
- Turnaround: one IDLE cycle is guaranteed between transactions. A pending request completing at edge m is next granted at edge m+1.

## Test plan
- Single request: N_REQ=4, `req`=4'b0100 from reset release, `res_done` pulsed 3 cycles after `res_start`.
  - Required: `gnt`=4'b0100, `gnt_id`=2.
  - Required: exactly one `res_start`, `done`=4'b0100 for one cycle, then `busy`=0.
- Round-robin contention: `req`=4'b1111 held, `res_done` 2 cycles after each start.
  - Required grant order: 0,1,2,3,0,1.
  - Required: one IDLE cycle between grants and never more than one `gnt` bit set.
- Watchdog: TIMEOUT=5, `req`=4'b0001, `res_done` never pulsed.
  - Required: `timeout` pulses exactly 5 cycles after START exits, `done` stays 0, and the next grant goes to the next pending requester.
- Simultaneous done and expiry: `res_done` arrives on the cycle where `wcnt`=TIMEOUT-1.
  - Required: `done` pulses and `timeout` stays 0.
- Reset mid-WAIT: `rst` asserted for 1 cycle during WAIT, then `res_done` pulsed.
  - Required: all outputs at reset values from the reset edge, no `done` or `timeout` pulse, and `ptr`=0 (next grant to the lowest requesting index).
- Request drop and stray done: grantee drops `req` during WAIT; additionally, `res_done` is pulsed while in IDLE.
  - Required: the transaction completes normally with `done` to the original grantee.
  - Required: the stray `res_done` causes no state change and no output activity.
